// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Every access moves one 64-bit doubleword
    localparam logic [3:0] XFER_BYTES = 4'b1000;

    // Requester port ids
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    // A doubleword access must sit on an 8-byte boundary
    function automatic logic is_misaligned(input logic [2:0] low_bits);
        return (low_bits != 3'b000);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner selection; purely combinational.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_id,
    output logic       o_valid
);

    // Lone requester always wins; on contention the port not granted last wins
    always_comb begin
        o_valid = |i_req;
        o_id    = PORT_CPU;
        if (i_req == 2'b11) begin
            o_id = ~i_last;
        end else if (i_req[1]) begin
            o_id = PORT_LDR;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the CPU and loader/debug ports onto a single data memory with
// a fixed issue-to-data latency. One access is in flight at a time.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              cpu_stall,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    output logic [3:0]        mem_xfer_size,
    input  logic [DATA_W-1:0] mem_read_data
);

    // WAIT cycles after ISSUE; zero means the data is ready during ISSUE
    localparam logic [3:0] LAT_M1    = 4'(MEM_LAT - 1);
    localparam logic       SKIP_WAIT = (MEM_LAT == 1);

    arb_state_t          r_state;
    arb_state_t          w_next;

    logic                r_id;
    logic                r_we;
    logic                r_mis;
    logic                r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [3:0]          r_cnt;

    logic                w_pick_id;
    logic                w_pick_vld;
    logic                w_latch;
    logic                w_last_beat;
    logic                w_capture;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    rr_pick2 u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_id    (w_pick_id),
        .o_valid (w_pick_vld)
    );

    // Route the winning port's fields toward the latch
    always_comb begin
        w_sel_we    = we[w_pick_id];
        w_sel_addr  = w_pick_id ? addr1  : addr0;
        w_sel_wdata = w_pick_id ? wdata1 : wdata0;
    end

    assign w_latch     = (r_state == IDLE) && w_pick_vld;
    // Memory data is valid during the last cycle before DONE
    assign w_last_beat = ((r_state == ISSUE) && SKIP_WAIT) ||
                         ((r_state == WAIT) && (r_cnt <= 4'd1));
    assign w_capture   = w_last_beat && !r_we && !r_mis;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_pick_vld) w_next = ISSUE;
            ISSUE:   w_next = (r_mis || SKIP_WAIT) ? DONE : WAIT;
            WAIT:    if (r_cnt <= 4'd1) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Latch the granted request, run the WAIT down-counter, track last grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_id    <= PORT_CPU;
            r_we    <= 1'b0;
            r_mis   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= 4'd0;
            // Pretend the loader went last so the CPU wins the first tie
            r_last  <= PORT_LDR;
        end else begin
            if (w_latch) begin
                r_id    <= w_pick_id;
                r_we    <= w_sel_we;
                r_mis   <= is_misaligned(w_sel_addr[2:0]);
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_cnt   <= LAT_M1;
            end else if (r_state == WAIT) begin
                r_cnt   <= r_cnt - 4'd1;
            end
            if (r_state == DONE) begin
                r_last  <= r_id;
            end
        end
    end

    // Load data register; writes and misaligned accesses leave it untouched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rdata <= mem_read_data;
        end
    end

    // Output decode: enables only in ISSUE, completion pulse only in DONE
    always_comb begin
        ack              = 2'b00;
        err              = 1'b0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        busy             = (r_state != IDLE);
        if ((r_state == ISSUE) && !r_mis) begin
            mem_write_enable = r_we;
            mem_read_enable  = ~r_we;
        end
        if (r_state == DONE) begin
            ack[r_id] = 1'b1;
            err       = r_mis;
        end
    end

    assign cpu_stall      = req[0] & ~ack[0];
    assign rdata          = r_rdata;
    assign mem_address    = r_addr;
    assign mem_write_data = r_wdata;
    assign mem_xfer_size  = XFER_BYTES;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one instance with MEM_LAT=1 (k=0), one with MEM_LAT=3 (k=1).
module tb_dmem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam logic [63:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [1:0]  t_req [2];
    logic [1:0]  t_we  [2];
    logic [63:0] t_a0  [2];
    logic [63:0] t_a1  [2];
    logic [63:0] t_d0  [2];
    logic [63:0] t_d1  [2];

    logic [1:0]  a_ack, b_ack;
    logic        a_err, b_err, a_stall, b_stall, a_busy, b_busy;
    logic [63:0] a_rdata, b_rdata, a_maddr, b_maddr, a_mwd, b_mwd, a_mrd, b_mrd;
    logic        a_mwe, b_mwe, a_mre, b_mre;
    logic [3:0]  a_xsz, b_xsz;

    logic [63:0] ref_mem [2][128];

    dmem_arbiter #(.MEM_LAT(1), .ADDR_W(AW), .DATA_W(DW)) u_a (
        .clk(clk), .reset(reset), .req(t_req[0]), .we(t_we[0]),
        .addr0(t_a0[0]), .addr1(t_a1[0]), .wdata0(t_d0[0]), .wdata1(t_d1[0]),
        .ack(a_ack), .err(a_err), .rdata(a_rdata), .cpu_stall(a_stall), .busy(a_busy),
        .mem_address(a_maddr), .mem_write_data(a_mwd), .mem_write_enable(a_mwe),
        .mem_read_enable(a_mre), .mem_xfer_size(a_xsz), .mem_read_data(a_mrd));

    dmem_arbiter #(.MEM_LAT(3), .ADDR_W(AW), .DATA_W(DW)) u_b (
        .clk(clk), .reset(reset), .req(t_req[1]), .we(t_we[1]),
        .addr0(t_a0[1]), .addr1(t_a1[1]), .wdata0(t_d0[1]), .wdata1(t_d1[1]),
        .ack(b_ack), .err(b_err), .rdata(b_rdata), .cpu_stall(b_stall), .busy(b_busy),
        .mem_address(b_maddr), .mem_write_data(b_mwd), .mem_write_enable(b_mwe),
        .mem_read_enable(b_mre), .mem_xfer_size(b_xsz), .mem_read_data(b_mrd));

    // Memory for k=0: data available combinationally in the issue cycle
    logic [63:0] mem_a [128];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 128; i++) mem_a[i] <= '0;
        end else if (a_mwe) begin
            mem_a[a_maddr[9:3]] <= a_mwd;
        end
    end
    assign a_mrd = a_mre ? mem_a[a_maddr[9:3]] : GARBAGE;

    // Memory for k=1: data available two cycles after the issue cycle
    logic [63:0] mem_b [128];
    logic        b_p1v, b_p2v;
    logic [6:0]  b_p1a, b_p2a;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 128; i++) mem_b[i] <= '0;
            b_p1v <= 1'b0; b_p2v <= 1'b0; b_p1a <= '0; b_p2a <= '0;
        end else begin
            if (b_mwe) mem_b[b_maddr[9:3]] <= b_mwd;
            b_p1v <= b_mre; b_p1a <= b_maddr[9:3];
            b_p2v <= b_p1v; b_p2a <= b_p1a;
        end
    end
    assign b_mrd = b_p2v ? mem_b[b_p2a] : GARBAGE;

    typedef struct packed {
        logic [1:0]  ack;
        logic        err;
        logic [63:0] rdata;
        logic        stall;
        logic        busy;
        logic [63:0] maddr;
        logic [63:0] mwd;
        logic        mwe;
        logic        mre;
        logic [3:0]  xsz;
    } obs_t;

    function automatic obs_t obs(input int k);
        obs_t o;
        if (k == 0) begin
            o.ack = a_ack; o.err = a_err; o.rdata = a_rdata; o.stall = a_stall; o.busy = a_busy;
            o.maddr = a_maddr; o.mwd = a_mwd; o.mwe = a_mwe; o.mre = a_mre; o.xsz = a_xsz;
        end else begin
            o.ack = b_ack; o.err = b_err; o.rdata = b_rdata; o.stall = b_stall; o.busy = b_busy;
            o.maddr = b_maddr; o.mwd = b_mwd; o.mwe = b_mwe; o.mre = b_mre; o.xsz = b_xsz;
        end
        return o;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            t_req[k] = 2'b00; t_we[k] = 2'b00;
            t_a0[k] = '0; t_a1[k] = '0; t_d0[k] = '0; t_d1[k] = '0;
            for (int i = 0; i < 128; i++) ref_mem[k][i] = '0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    // One access on port p; reports cycle of ack relative to the request cycle
    task automatic access(input int k, input int p, input bit w, input logic [63:0] a,
                          input logic [63:0] d, output int lat, output int ens,
                          output int en_at, output logic e_at_ack, output logic st_at_ack,
                          output logic [63:0] rd_at_ack);
        obs_t o;
        tick();
        t_we[k][p] = w;
        if (p == 0) begin t_a0[k] = a; t_d0[k] = d; end
        else        begin t_a1[k] = a; t_d1[k] = d; end
        t_req[k][p] = 1'b1;
        lat = -1; ens = 0; en_at = -1; e_at_ack = 1'b0; st_at_ack = 1'b1; rd_at_ack = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            o = obs(k);
            if (o.mwe || o.mre) begin
                ens++;
                if (en_at < 0) en_at = c;
            end
            if (o.ack[p]) begin
                lat = c; e_at_ack = o.err; st_at_ack = o.stall; rd_at_ack = o.rdata;
                break;
            end
            tick();
        end
        tick();
        t_req[k][p] = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        clear_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            o = obs(k);
            total++; if (o.ack !== 2'b00) begin bad++; $display("FAIL reset_ack k=%0d got=%b exp=00", k, o.ack); end
            total++; if (o.err !== 1'b0) begin bad++; $display("FAIL reset_err k=%0d got=%b exp=0", k, o.err); end
            total++; if (o.busy !== 1'b0) begin bad++; $display("FAIL reset_busy k=%0d got=%b exp=0", k, o.busy); end
            total++; if ({o.mwe, o.mre} !== 2'b00) begin bad++; $display("FAIL reset_en k=%0d got=%b exp=00", k, {o.mwe, o.mre}); end
            total++; if (o.rdata !== 64'd0) begin bad++; $display("FAIL reset_rdata k=%0d got=%h exp=0", k, o.rdata); end
            total++; if (o.xsz !== 4'b1000) begin bad++; $display("FAIL xfer_size k=%0d got=%b exp=1000", k, o.xsz); end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            o = obs(k);
            total++; if (o.busy !== 1'b0) begin bad++; $display("FAIL idle_busy k=%0d got=%b exp=0", k, o.busy); end
        end
    endtask

    task automatic test_alternate(input int k);
        int order[$];
        int when[$];
        obs_t o;
        int L;
        L = lat_of(k);
        tick();
        t_we[k] = 2'b00; t_a0[k] = 64'h40; t_a1[k] = 64'h48; t_req[k] = 2'b11;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            o = obs(k);
            if (o.ack != 2'b00) begin
                order.push_back(int'(o.ack[1]));
                when.push_back(c);
            end
            if (order.size() == 4) break;
            tick();
        end
        tick();
        t_req[k] = 2'b00;
        total++;
        if (order.size() != 4) begin bad++; $display("FAIL alt_count k=%0d got=%0d exp=4", k, order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            total++;
            if (order[i] != (i % 2)) begin bad++; $display("FAIL alt_order k=%0d i=%0d got=%0d exp=%0d", k, i, order[i], i % 2); end
            total++;
            if (when[i] != (L + 1) + i * (L + 2)) begin
                bad++; $display("FAIL alt_cycle k=%0d i=%0d got=%0d exp=%0d", k, i, when[i], (L + 1) + i * (L + 2));
            end
        end
    endtask

    task automatic test_lat1_read();
        int lat, ens, en_at;
        logic e, st;
        logic [63:0] rd;
        access(0, 1, 1'b1, 64'h10, 64'hDEAD, lat, ens, en_at, e, st, rd);
        total++; if (lat != 2) begin bad++; $display("FAIL l1_wr_lat got=%0d exp=2", lat); end
        access(0, 0, 1'b0, 64'h10, 64'h0, lat, ens, en_at, e, st, rd);
        total++; if (en_at != 1) begin bad++; $display("FAIL l1_rd_en_cycle got=%0d exp=1", en_at); end
        total++; if (lat != 2) begin bad++; $display("FAIL l1_rd_lat got=%0d exp=2", lat); end
        total++; if (rd !== 64'hDEAD) begin bad++; $display("FAIL l1_rdata got=%h exp=dead", rd); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL l1_err got=%b exp=0", e); end
    endtask

    task automatic test_lat3_write();
        int lat, ens, en_at;
        logic e, st;
        logic [63:0] rd;
        access(1, 1, 1'b1, 64'h20, 64'h1234, lat, ens, en_at, e, st, rd);
        total++; if (ens != 1) begin bad++; $display("FAIL l3_wr_en_cycles got=%0d exp=1", ens); end
        total++; if (lat != 4) begin bad++; $display("FAIL l3_wr_lat got=%0d exp=4", lat); end
        access(1, 0, 1'b0, 64'h20, 64'h0, lat, ens, en_at, e, st, rd);
        total++; if (lat != 4) begin bad++; $display("FAIL l3_rd_lat got=%0d exp=4", lat); end
        total++; if (rd !== 64'h1234) begin bad++; $display("FAIL l3_rdata got=%h exp=1234", rd); end
    endtask

    task automatic test_misaligned(input int k, input logic [63:0] base, input logic [63:0] expd);
        int lat, ens, en_at;
        logic e, st;
        logic [63:0] rd;
        access(k, 0, 1'b0, base + 64'd3, 64'h0, lat, ens, en_at, e, st, rd);
        total++; if (lat != 2) begin bad++; $display("FAIL mis_rd_lat k=%0d got=%0d exp=2", k, lat); end
        total++; if (ens != 0) begin bad++; $display("FAIL mis_rd_en k=%0d got=%0d exp=0", k, ens); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL mis_rd_err k=%0d got=%b exp=1", k, e); end
        total++; if (rd !== expd) begin bad++; $display("FAIL mis_rdata k=%0d got=%h exp=%h", k, rd, expd); end
        total++; if (st !== 1'b0) begin bad++; $display("FAIL mis_stall k=%0d got=%b exp=0", k, st); end
        access(k, 1, 1'b1, base + 64'd1, 64'h9999, lat, ens, en_at, e, st, rd);
        total++; if (ens != 0) begin bad++; $display("FAIL mis_wr_en k=%0d got=%0d exp=0", k, ens); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL mis_wr_err k=%0d got=%b exp=1", k, e); end
        access(k, 0, 1'b0, base, 64'h0, lat, ens, en_at, e, st, rd);
        total++; if (lat != lat_of(k) + 1) begin bad++; $display("FAIL mis_after_lat k=%0d got=%0d exp=%0d", k, lat, lat_of(k) + 1); end
        total++; if (rd !== expd) begin bad++; $display("FAIL mis_after_rdata k=%0d got=%h exp=%h", k, rd, expd); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL mis_after_err k=%0d got=%b exp=0", k, e); end
    endtask

    task automatic test_reset_midwait();
        obs_t o;
        int lat, ens, en_at;
        logic e, st;
        logic [63:0] rd;
        int acks;
        tick();
        t_we[1][0] = 1'b0; t_a0[1] = 64'h20; t_req[1][0] = 1'b1;
        tick();
        tick();
        @(negedge clk);
        o = obs(1);
        total++; if ({o.busy, o.mre} !== 2'b10) begin bad++; $display("FAIL midwait_pre got=%b exp=10", {o.busy, o.mre}); end
        tick();
        #2 reset = 1'b0;
        #1 o = obs(1);
        total++; if (o.busy !== 1'b0) begin bad++; $display("FAIL midwait_busy got=%b exp=0", o.busy); end
        total++; if ({o.mwe, o.mre} !== 2'b00) begin bad++; $display("FAIL midwait_en got=%b exp=00", {o.mwe, o.mre}); end
        total++; if (o.ack !== 2'b00) begin bad++; $display("FAIL midwait_ack got=%b exp=00", o.ack); end
        total++; if (o.rdata !== 64'd0) begin bad++; $display("FAIL midwait_rdata got=%h exp=0", o.rdata); end
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            o = obs(1);
            if (o.ack != 2'b00 || o.busy) acks++;
        end
        total++; if (acks != 0) begin bad++; $display("FAIL midwait_abandon got=%0d exp=0", acks); end
        access(1, 1, 1'b1, 64'h20, 64'h77, lat, ens, en_at, e, st, rd);
        access(1, 0, 1'b0, 64'h20, 64'h0, lat, ens, en_at, e, st, rd);
        total++; if (lat != 4) begin bad++; $display("FAIL post_reset_lat got=%0d exp=4", lat); end
        total++; if (rd !== 64'h77) begin bad++; $display("FAIL post_reset_rdata got=%h exp=77", rd); end
    endtask

    task automatic test_random(input int k, input int ncyc);
        int L;
        bit pend[2];
        bit ack_prev[2];
        bit m_act, m_we, m_mis;
        int m_n, m_port, m_last, issue_c, ack_c;
        logic [63:0] m_addr, m_wd, m_rd, a, d;
        logic [1:0] e_ack;
        logic e_busy, e_re, e_wr, e_err, e_stall;
        obs_t o;
        L = lat_of(k);
        apply_reset();
        pend = '{1'b0, 1'b0}; ack_prev = '{1'b0, 1'b0};
        m_act = 1'b0; m_we = 1'b0; m_mis = 1'b0; m_n = 0; m_port = 0; m_last = 1;
        m_addr = '0; m_wd = '0; m_rd = '0;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (ack_prev[p]) begin pend[p] = 1'b0; t_req[k][p] = 1'b0; end
                if (!pend[p]) begin
                    if ($urandom_range(2) == 0) begin
                        a = 64'($urandom_range(127)) << 3;
                        if ($urandom_range(7) == 0) a[2:0] = 3'($urandom_range(7, 1));
                        d = {$urandom, $urandom};
                        t_we[k][p] = 1'($urandom_range(1));
                        if (p == 0) begin t_a0[k] = a; t_d0[k] = d; end
                        else        begin t_a1[k] = a; t_d1[k] = d; end
                        t_req[k][p] = 1'b1;
                        pend[p] = 1'b1;
                    end
                end else if (m_act && m_port == p && $urandom_range(3) == 0) begin
                    t_req[k][p] = 1'b0;
                end
            end
            @(negedge clk);
            o = obs(k);
            issue_c = m_n + 1;
            ack_c   = m_n + 1 + (m_mis ? 1 : L);
            e_ack = 2'b00; e_busy = 1'b0; e_re = 1'b0; e_wr = 1'b0; e_err = 1'b0;
            if (m_act) begin
                e_busy = 1'b1;
                if (c == issue_c && !m_mis) begin e_re = !m_we; e_wr = m_we; end
                if (c == ack_c) begin
                    e_ack[m_port] = 1'b1;
                    e_err = m_mis;
                    if (!m_mis && !m_we) m_rd = ref_mem[k][m_addr[9:3]];
                    if (!m_mis && m_we) ref_mem[k][m_addr[9:3]] = m_wd;
                end
            end
            e_stall = t_req[k][0] & ~e_ack[0];
            total++; if (o.ack !== e_ack) begin bad++; $display("FAIL rnd_ack k=%0d c=%0d got=%b exp=%b", k, c, o.ack, e_ack); end
            total++; if (o.busy !== e_busy) begin bad++; $display("FAIL rnd_busy k=%0d c=%0d got=%b exp=%b", k, c, o.busy, e_busy); end
            total++; if ({o.mre, o.mwe} !== {e_re, e_wr}) begin bad++; $display("FAIL rnd_en k=%0d c=%0d got=%b exp=%b", k, c, {o.mre, o.mwe}, {e_re, e_wr}); end
            total++; if (o.rdata !== m_rd) begin bad++; $display("FAIL rnd_rdata k=%0d c=%0d got=%h exp=%h", k, c, o.rdata, m_rd); end
            total++; if (o.stall !== e_stall) begin bad++; $display("FAIL rnd_stall k=%0d c=%0d got=%b exp=%b", k, c, o.stall, e_stall); end
            if (e_ack != 2'b00) begin
                total++; if (o.err !== e_err) begin bad++; $display("FAIL rnd_err k=%0d c=%0d got=%b exp=%b", k, c, o.err, e_err); end
            end
            if (m_act && c == issue_c) begin
                total++; if (o.maddr !== m_addr) begin bad++; $display("FAIL rnd_addr k=%0d c=%0d got=%h exp=%h", k, c, o.maddr, m_addr); end
                if (m_we) begin
                    total++; if (o.mwd !== m_wd) begin bad++; $display("FAIL rnd_wdata k=%0d c=%0d got=%h exp=%h", k, c, o.mwd, m_wd); end
                end
            end
            ack_prev[0] = o.ack[0];
            ack_prev[1] = o.ack[1];
            if (m_act && c == ack_c) begin
                m_act = 1'b0;
                m_last = m_port;
            end else if (!m_act && t_req[k] != 2'b00) begin
                if (t_req[k] == 2'b11) m_port = 1 - m_last;
                else                   m_port = t_req[k][1] ? 1 : 0;
                m_we   = t_we[k][m_port];
                m_addr = (m_port == 0) ? t_a0[k] : t_a1[k];
                m_wd   = (m_port == 0) ? t_d0[k] : t_d1[k];
                m_mis  = (m_addr[2:0] != 3'b000);
                m_act  = 1'b1;
                m_n    = c;
            end
        end
    endtask

    initial begin
        test_reset();
        test_alternate(0);
        test_alternate(1);
        test_lat1_read();
        test_lat3_write();
        test_misaligned(0, 64'h10, 64'hDEAD);
        test_misaligned(1, 64'h20, 64'h1234);
        test_reset_midwait();
        test_random(0, 400);
        test_random(1, 400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, SHALL set the cycles from memory issue to valid mem_read_data (legal range 1..15).
REQ-002 Parameter ADDR_W, default 64, SHALL set the address width.
REQ-003 Parameter DATA_W, default 64, SHALL set the data width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be asynchronous, active-low reset.
REQ-006 req[1:0]  in  2  SHALL carry the access requests: port 0 = CPU, port 1 = loader/debug.
REQ-007 we[1:0]  in  2  SHALL select per-port write (1) or read (0).
REQ-008 addr0, addr1  in  ADDR_W  SHALL carry the per-port byte addresses.
REQ-009 wdata0, wdata1  in  DATA_W  SHALL carry the per-port store data.
REQ-010 ack[1:0]  out  2  SHALL be a one-cycle per-port completion pulse.
REQ-011 err  out  1  SHALL flag a misaligned access, valid only with ack.
REQ-012 rdata  out  DATA_W  SHALL carry registered load data.
REQ-013 cpu_stall  out  1  SHALL equal req[0] & ~ack[0].
REQ-014 busy  out  1  SHALL be high in every state except IDLE.
REQ-015 mem_address  out  ADDR_W  SHALL drive the datamem address.
REQ-016 mem_write_data  out  DATA_W  SHALL drive the datamem store data.
REQ-017 mem_write_enable, mem_read_enable  out  1 each  SHALL drive the datamem enables.
REQ-018 mem_xfer_size  out  4  SHALL drive the datamem transfer size.
REQ-019 mem_read_data  in  DATA_W  SHALL receive the datamem load data.

Function
REQ-020 FSM SHALL use states IDLE, ISSUE, WAIT, DONE.
REQ-021 IDLE: if any req is high, the arbiter SHALL select a winner, latch its id/we/addr/wdata, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-022 Selection SHALL be round-robin; when both ports request, the port not granted last SHALL win, and a single requester SHALL always win.
REQ-023 ISSUE (exactly 1 cycle): mem_address/mem_write_data SHALL equal the latched values, and exactly one enable SHALL be high per the latched we.
REQ-024 The enables SHALL be low in every state other than ISSUE; mem_xfer_size SHALL be constant 4'b1000.
REQ-025 After ISSUE, the FSM SHALL spend MEM_LAT-1 cycles in WAIT (down-counter), then enter DONE; MEM_LAT=1 SHALL skip WAIT.
REQ-026 For a read, rdata SHALL capture mem_read_data on the edge leaving the final ISSUE/WAIT cycle; writes SHALL leave rdata unchanged.
REQ-027 DONE (1 cycle): ack[id] SHALL be high; the round-robin pointer SHALL update to id; the next state SHALL be IDLE.
REQ-028 Latency: req first high in IDLE cycle N SHALL produce ack in cycle N+1+MEM_LAT.
REQ-029 Misaligned access (addr[2:0]!=0): ISSUE SHALL assert no enable, WAIT SHALL be skipped, DONE SHALL assert ack[id] and err=1, and rdata SHALL be unchanged.
REQ-030 Requesters SHALL hold req and all fields stable until ack; req dropped after latching SHALL NOT abort the access, and ack SHALL still pulse.
REQ-031 req sampled in the cycle after DONE SHALL be treated as a new request (back-to-back legal; a one-cycle IDLE gap between accesses is mandatory).
REQ-032 The non-selected port SHALL wait without loss; with both ports held high, grants SHALL alternate 0,1,0,1.

Reset
REQ-033 On reset low, the FSM SHALL go to IDLE immediately and asynchronously.
REQ-034 On reset low, ack, err, busy, mem_write_enable and mem_read_enable SHALL be 0.
REQ-035 On reset low, rdata, the latched fields and the WAIT counter SHALL be 0, and the RR pointer SHALL be set so port 0 wins the first contention.
REQ-036 Reset mid-transaction SHALL abandon it with no ack, and the first post-reset request SHALL restart from IDLE.

Structure
REQ-037 Package dmem_arb_pkg SHALL hold the state enum, XFER_BYTES=4'b1000, and the PORT_CPU=0 / PORT_LDR=1 constants.
REQ-038 Winner selection SHALL live in sub-module rr_pick2 (combinational: req[1:0] + last -> grant id, valid).
REQ-039 The remaining FSM, latches and counter SHALL reside in dmem_arbiter.

Verification
REQ-040 MEM_LAT=1: CPU reads addr 0x10 (memory holds 0xDEAD) from IDLE at cycle N -> read enable high in N+1, ack[0] in N+2, rdata=0xDEAD, err=0.
REQ-041 MEM_LAT=3: loader writes 0x1234 to 0x20 -> write enable for exactly one cycle, ack[1] at N+4, and a subsequent CPU read of 0x20 returns 0x1234.
REQ-042 Both ports request at once after reset and are held high for 4 accesses -> grant order 0,1,0,1 with a one-cycle IDLE between accesses.
REQ-043 CPU read of addr 0x13 -> no enable asserted, ack[0] with err=1 at N+2, rdata unchanged, cpu_stall low after ack.
REQ-044 MEM_LAT=3: reset asserted during WAIT -> enables, busy and ack go 0 immediately; after release a new CPU request completes normally.
